reg_write_arbiter: RTL

Shares the register file's single write port between two writeback requesters: the ALU/execute path (requester 0) and the multi-cycle/load path (requester 1). Each requester uses a valid/ready handshake. A two-way round-robin arbiter grants one request per cycle, and the winner is registered into an output stage that drives `reg_write_i`, `write_register_i` and `write_data_i` of `Register_File`. Writes to `$zero` are absorbed and never reach the port.

---
 rtl/reg_write_arb_pkg.sv | 13 +
 rtl/reg_write_arbiter_rr_arbiter_2.sv | 45 ++++
 rtl/reg_write_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/reg_write_arb_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Optional bypass feature is enabled by RF_WRITE_BYPASS_EN.
package reg_write_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter_2.sv
// Two-request round-robin arbiter with one-hot grant.
// The priority pointer flips to the loser after every grant.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  import reg_write_arb_pkg::*;

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = 2'b00;
    if (!reset && !hold_i) begin
      unique case (1'b1)
        (req_i == 2'b11): gnt_o = prio_q ? 2'b10 : 2'b01;
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        default:          gnt_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = REQ_MEM;
    end else if (gnt_o[1]) begin
      prio_d = REQ_ALU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between ALU and load paths.
// Define RF_WRITE_BYPASS_EN to add the read-side forwarding muxes.
module reg_write_arbiter #(
  parameter int DATA_WIDTH = reg_write_arb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_write_arb_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  reg_write_o,
  output logic [ADDR_WIDTH-1:0] write_register_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  grant_o,
  output logic                  zero_drop_o
`ifdef RF_WRITE_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0] read_register_1_i,
  input  logic [ADDR_WIDTH-1:0] read_register_2_i,
  input  logic [DATA_WIDTH-1:0] rf_read_data_1_i,
  input  logic [DATA_WIDTH-1:0] rf_read_data_2_i,
  output logic [DATA_WIDTH-1:0] read_data_1_o,
  output logic [DATA_WIDTH-1:0] read_data_2_o
`endif
);

  import reg_write_arb_pkg::*;

  logic [1:0]            gnt;
  logic                  xfer;
  logic                  win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_zero;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .hold_i (hold_i),
    .req_i  ({req1_valid_i, req0_valid_i}),
    .gnt_o  (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  // A grant is only ever given to a valid requester.
  assign xfer     = |gnt;
  assign win_id   = gnt[1] ? REQ_MEM : REQ_ALU;
  assign win_addr = gnt[1] ? req1_addr_i : req0_addr_i;
  assign win_data = gnt[1] ? req1_data_i : req0_data_i;
  assign win_zero = (win_addr == ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_o      <= 1'b0;
      zero_drop_o      <= 1'b0;
      write_register_o <= '0;
      write_data_o     <= '0;
      grant_o          <= REQ_ALU;
    end else begin
      reg_write_o <= xfer && !win_zero;
      zero_drop_o <= xfer && win_zero;
      if (xfer) begin
        write_register_o <= win_addr;
        write_data_o     <= win_data;
        grant_o          <= win_id;
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  always_comb begin
    read_data_1_o = rf_read_data_1_i;
    read_data_2_o = rf_read_data_2_i;
    if (reg_write_o &&
        write_register_o == read_register_1_i) begin
      read_data_1_o = write_data_o;
    end
    if (reg_write_o &&
        write_register_o == read_register_2_i) begin
      read_data_2_o = write_data_o;
    end
  end
`endif

endmodule
